// File: rtl/io_sched.sv
// io_sched: round-robin scheduler sharing one input holding register among four 8-bit devices.
// Define IO_SCHED_PRIO_EN to replace round-robin with fixed priority A>B>C>D.
module io_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] datos_inA,
    input  logic [WIDTH-1:0] datos_inB,
    input  logic [WIDTH-1:0] datos_inC,
    input  logic [WIDTH-1:0] datos_inD,
    output logic [3:0]       ack,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       src,
    output logic             valid,
    output logic [7:0]       cnt
);

    typedef enum logic {
        IDLE,
        FULL
    } state_t;

    state_t           state_reg;
    logic [3:0]       ack_reg;
    logic [WIDTH-1:0] dout_reg;
    logic [1:0]       src_reg;
    logic             valid_reg;
    logic [7:0]       cnt_reg;

    logic [WIDTH-1:0] dev_data [4];
    logic [1:0]       grant_next;
    logic             grant_any;

    assign dev_data[0] = datos_inA;
    assign dev_data[1] = datos_inB;
    assign dev_data[2] = datos_inC;
    assign dev_data[3] = datos_inD;

    assign grant_any = |req;

`ifdef IO_SCHED_PRIO_EN
    // Fixed priority: lowest set request bit wins.
    always_comb begin
        grant_next = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                grant_next = 2'(k);
            end
        end
    end
`else
    logic [1:0] ptr_reg;

    // Search upward from ptr with wrap; scanning offsets downward lets the
    // smallest offset (closest to ptr) overwrite any later candidate.
    always_comb begin
        logic [1:0] idx;
        grant_next = ptr_reg;
        idx        = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_reg + 2'(k);
            if (req[idx]) begin
                grant_next = idx;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ack_reg   <= 4'b0000;
            dout_reg  <= '0;
            src_reg   <= 2'd0;
            valid_reg <= 1'b0;
            cnt_reg   <= 8'd0;
`ifndef IO_SCHED_PRIO_EN
            ptr_reg   <= 2'd0;
`endif
        end else begin
            ack_reg <= 4'b0000;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        dout_reg  <= dev_data[grant_next];
                        src_reg   <= grant_next;
                        valid_reg <= 1'b1;
                        ack_reg   <= 4'b0001 << grant_next;
`ifndef IO_SCHED_PRIO_EN
                        ptr_reg   <= grant_next + 2'd1;
`endif
                        state_reg <= FULL;
                    end
                end
                FULL: begin
                    // Requests are ignored until the held byte is consumed.
                    if (rd) begin
                        valid_reg <= 1'b0;
                        cnt_reg   <= cnt_reg + 8'd1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ack   = ack_reg;
    assign dout  = dout_reg;
    assign src   = src_reg;
    assign valid = valid_reg;
    assign cnt   = cnt_reg;

endmodule

// File: tb/tb_io_sched.sv
// Directed self-checking bench for io_sched (round-robin or fixed-priority build).
`timescale 1ns/1ps
module tb_io_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [7:0] datos_inA, datos_inB, datos_inC, datos_inD;
    logic [3:0] ack;
    logic       rd;
    logic [7:0] dout;
    logic [1:0] src;
    logic       valid;
    logic [7:0] cnt;

    int n_compared = 0;
    int n_mismatch = 0;

    io_sched #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .datos_inA (datos_inA),
        .datos_inB (datos_inB),
        .datos_inC (datos_inC),
        .datos_inD (datos_inD),
        .ack       (ack),
        .rd        (rd),
        .dout      (dout),
        .src       (src),
        .valid     (valid),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] exp_src [5];
    logic [7:0] exp_byte [4];
    logic [3:0] ack_seen;

    initial begin
        reset = 1'b1;
        req = 4'b0000;
        rd = 1'b0;
        datos_inA = 8'h11;
        datos_inB = 8'h22;
        datos_inC = 8'h33;
        datos_inD = 8'h44;
        exp_byte[0] = 8'h11;
        exp_byte[1] = 8'h22;
        exp_byte[2] = 8'h33;
        exp_byte[3] = 8'h44;
`ifdef IO_SCHED_PRIO_EN
        exp_src[0] = 2'd0; exp_src[1] = 2'd0; exp_src[2] = 2'd0; exp_src[3] = 2'd0; exp_src[4] = 2'd0;
`else
        exp_src[0] = 2'd0; exp_src[1] = 2'd1; exp_src[2] = 2'd2; exp_src[3] = 2'd3; exp_src[4] = 2'd0;
`endif

        // Reset state and a single grant to A
        do_reset();
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_ack", 32'(ack), 32'h0);
        check_eq("rst_dout", 32'(dout), 32'h0);
        check_eq("rst_src", 32'(src), 32'h0);
        check_eq("rst_cnt", 32'(cnt), 32'h0);
        datos_inA = 8'h5A;
        req = 4'b0001;
        tick();
        check_eq("g1_dout", 32'(dout), 32'h5A);
        check_eq("g1_src", 32'(src), 32'h0);
        check_eq("g1_valid", 32'(valid), 32'h1);
        check_eq("g1_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        tick();
        check_eq("g1_ack_drop", 32'(ack), 32'h0);
        check_eq("g1_valid_hold", 32'(valid), 32'h1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check_eq("g1_rd_valid", 32'(valid), 32'h0);
        check_eq("g1_rd_cnt", 32'(cnt), 32'h1);

        // All four requesting, rd after every grant
        do_reset();
        datos_inA = 8'h11;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("rr%0d_src", i), 32'(src), 32'(exp_src[i]));
            check_eq($sformatf("rr%0d_dout", i), 32'(dout), 32'(exp_byte[exp_src[i]]));
            check_eq($sformatf("rr%0d_ack", i), 32'(ack), 32'(4'b0001 << exp_src[i]));
            rd = 1'b1;
            tick();
            rd = 1'b0;
            check_eq($sformatf("rr%0d_rel", i), 32'(valid), 32'h0);
        end
        req = 4'b0000;
        check_eq("rr_cnt", 32'(cnt), 32'd5);

        // Byte held while C requests: nothing changes until rd
        req = 4'b0001;
        tick();
        check_eq("hold_src", 32'(src), 32'h0);
        req = 4'b0100;
        ack_seen = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            ack_seen = ack_seen | ack;
        end
        check_eq("hold_dout", 32'(dout), 32'h11);
        check_eq("hold_ack", 32'(ack_seen), 32'h0);
        check_eq("hold_valid", 32'(valid), 32'h1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check_eq("hold_rel", 32'(valid), 32'h0);
        tick();
        check_eq("hold_gC_src", 32'(src), 32'h2);
        check_eq("hold_gC_dout", 32'(dout), 32'h33);
        check_eq("hold_gC_ack", 32'(ack), 32'h4);
        req = 4'b0000;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check_eq("hold_cnt", 32'(cnt), 32'd7);

        // rd with nothing held is ignored
        rd = 1'b1;
        tick();
        tick();
        rd = 1'b0;
        check_eq("idle_rd_cnt", 32'(cnt), 32'd7);
        check_eq("idle_rd_valid", 32'(valid), 32'h0);

        // 256 grant/read pairs wrap the counter
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 256; i++) begin
            tick();
            rd = 1'b1;
            tick();
            rd = 1'b0;
            if (i == 254) check_eq("wrap_255", 32'(cnt), 32'd255);
        end
        req = 4'b0000;
        check_eq("wrap_0", 32'(cnt), 32'd0);
        check_eq("wrap_src", 32'(src), 32'h1);

        // Reset in the same cycle as rd while FULL
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check_eq("rr_full", 32'(valid), 32'h1);
        rd = 1'b1;
        reset = 1'b1;
        tick();
        rd = 1'b0;
        reset = 1'b0;
        check_eq("rr_valid", 32'(valid), 32'h0);
        check_eq("rr_cnt0", 32'(cnt), 32'h0);
        check_eq("rr_dout0", 32'(dout), 32'h0);
        req = 4'b1010;
        tick();
        check_eq("rr_gB_src", 32'(src), 32'h1);
        check_eq("rr_gB_dout", 32'(dout), 32'h22);
        check_eq("rr_gB_ack", 32'(ack), 32'h2);
        req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/io_sched.md
# io_sched

Round-robin input scheduler that shares the processor's single input path among four external 8-bit devices. Each device raises a request with its byte. The block grants one device, captures its byte into a one-entry holding register and acknowledges it. The processor then consumes the byte with a read strobe. It sits between the external devices and the datapath input mux, in place of the four raw input ports, and gives the program ordered, lossless input.

## Interface
- WIDTH, 8, data width of device bytes and holding register
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req  in  4  device requests, bit i = device i (0=A … 3=D)
- datos_inA  in  WIDTH  device A byte, stable while req[0]=1
- datos_inB  in  WIDTH  device B byte, stable while req[1]=1
- datos_inC  in  WIDTH  device C byte, stable while req[2]=1
- datos_inD  in  WIDTH  device D byte, stable while req[3]=1
- ack  out  4  one-cycle pulse to the granted device when its byte is captured
- rd  in  1  processor read strobe; consumes the held byte
- dout  out  WIDTH  held byte
- src  out  2  index of the device that supplied dout
- valid  out  1  holding register full
- cnt  out  8  bytes delivered to the processor, wraps 255→0

## Operation
- States: IDLE (register empty, arbitrating) and FULL (byte held, waiting for rd).
- IDLE, req==0: stay in IDLE; outputs unchanged.
- IDLE, req!=0: grant g = first set bit of req searching upward from ptr, wrapping 3→0. Register the following:
  - dout = datos_in[g], src = g, valid = 1
  - ack = one-hot(g) for one cycle
  - ptr = (g+1) mod 4
  - go to FULL
- FULL: hold dout, src and valid; ack = 0; ignore req.
- FULL, rd=1: valid = 0, cnt = cnt+1 (mod 256), go to IDLE. dout and src keep their last values.
- rd while valid=0: ignored; no count, no state change.
- After a device sees ack it must drop req. A req still high in the next IDLE cycle is treated as a new request.
- ptr is 2 bits, with reset value 0, so after reset device A has first priority.
- A device with req held continuously is served at least once every 4 grants. There is no starvation.

## Timing
- Reset values: valid=0, ack=0000, dout=0, src=0, cnt=0, ptr=0, state IDLE.
- Grant latency: req sampled in IDLE at edge t makes dout, src, valid and ack visible after edge t (one cycle).
- Release: rd sampled at edge t gives valid=0 after edge t. The earliest next grant is at edge t+1.
- Maximum throughput: one byte per 2 cycles.
- rd and req asserted in the same cycle while FULL: rd completes first, and the req is granted on the following edge.
- Reset in the same cycle as rd or a grant: reset wins; the byte is discarded and cnt is not incremented.
- ack is never asserted for more than one cycle per grant. ack and valid rise on the same edge.

## Configuration
- IO_SCHED_PRIO_EN defined: round-robin is replaced by fixed priority A>B>C>D. ptr is not implemented, and g is the lowest set bit of req.
- IO_SCHED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Reset, then req=0001, datos_inA=8'h5A → next cycle dout=5A, src=0, valid=1, ack=0001; the cycle after, ack=0000.
- req=1111 held, with each device giving a distinct byte (A=11, B=22, C=33, D=44); pulse rd after every grant → grant order A,B,C,D,A; cnt=5 after 5 reads. With IO_SCHED_PRIO_EN defined → every grant goes to A.
- Byte held, req=0100, no rd for 10 cycles → dout unchanged, ack stays 0000; rd → valid=0, then the next edge grants C.
- rd pulsed with valid=0 → cnt and state unchanged.
- 256 grant/read pairs → cnt wraps to 0.
- Reset asserted in the same cycle as rd while FULL → valid=0, cnt=0, ptr=0; the next req=1010 grants B.
